// File: rtl/pea_pkg.sv
// Shared constants for the processing-element array.
package pea_pkg;
  localparam int unsigned N_CFG_BITS_PE = 8;
endpackage

// File: rtl/dae_pe_cfg_loader.sv
// Double-buffered per-PE control word loader: a streamed shadow bank is
// copied atomically into the active bank that drives every PE.
module dae_pe_cfg_loader #(
  parameter int unsigned N_PE  = 16,
  parameter int unsigned CFG_W = pea_pkg::N_CFG_BITS_PE,
  parameter int unsigned CNT_W = $clog2(N_PE)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        load_start_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [31:0]                 cfg_data_i,
  input  logic                        commit_i,
  output logic                        busy_o,
  output logic                        shadow_full_o,
  output logic                        err_o,
  output logic [N_PE-1:0][CFG_W-1:0]  ctrl_pe_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [N_PE-1:0][CFG_W-1:0]  shadow_q, shadow_d;
  logic [N_PE-1:0][CFG_W-1:0]  active_q, active_d;
  logic                        err_q, err_d;
  logic                        accept_s;

  if (CFG_W < 32) begin : g_unused_hi
    logic unused_hi_s;
    assign unused_hi_s = ^cfg_data_i[31:CFG_W];
  end

  // Handshake and status flags decode from registered state only.
  assign cfg_ready_o   = (state_q == ST_LOAD);
  assign busy_o        = (state_q == ST_LOAD);
  assign shadow_full_o = (state_q == ST_FULL);
  assign err_o         = err_q;
  assign ctrl_pe_o     = active_q;
  assign accept_s      = cfg_valid_i & cfg_ready_o;

  // Next-state, counter, bank and error computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A restart discards any word accepted in the same cycle.
        if (load_start_i) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
          shadow_d[cnt_q] = cfg_data_i[CFG_W-1:0];
          if (cnt_q == CNT_W'(N_PE - 1)) begin
            state_d = ST_FULL;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FULL: begin
        if (commit_i) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end else begin
          active_d = active_q;
        end
        if (load_start_i) begin
          state_d = ST_LOAD;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Setting on an illegal commit takes priority over clearing on restart.
    if (commit_i && (state_q != ST_FULL)) begin
      err_d = 1'b1;
    end else if (load_start_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State, banks and sticky error register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dae_pe_cfg_loader.sv
// Directed self-checking bench for dae_pe_cfg_loader (16 PEs, 8-bit words).
module tb_dae_pe_cfg_loader;

  localparam int N = 16;
  localparam int W = 8;

  logic               clk;
  logic               rst_n;
  logic               load_start;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_data;
  logic               commit;
  logic               busy;
  logic               shadow_full;
  logic               err;
  logic [N-1:0][W-1:0] ctrl;

  int compared;
  int mismatched;

  dae_pe_cfg_loader #(.N_PE(N), .CFG_W(W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .load_start_i  (load_start),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_data_i    (cfg_data),
    .commit_i      (commit),
    .busy_o        (busy),
    .shadow_full_o (shadow_full),
    .err_o         (err),
    .ctrl_pe_o     (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
    logic [N-1:0][W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base);
    logic [N-1:0][W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = base + W'(i);
    return r;
  endfunction

  task automatic load_all(input logic [7:0] val);
    for (int i = 0; i < N; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = {24'hFFFF00, val};
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 32'h0;
    commit     = 1'b0;
    #12;
    check("rst_ctrl",  ctrl, rep(8'h00));
    check("rst_ready", {127'b0, cfg_ready}, 128'd0);
    check("rst_flags", {125'b0, busy, shadow_full, err}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Illegal commit in IDLE, then clear on restart
    pulse_commit();
    check("idle_commit_err",  {127'b0, err}, 128'd1);
    check("idle_commit_ctrl", ctrl, rep(8'h00));
    pulse_start();
    check("start_clears_err", {127'b0, err}, 128'd0);
    check("start_busy_ready", {126'b0, busy, cfg_ready}, 128'd3);

    // Full load of i+1 with valid held, plus back-pressured extra words
    for (int i = 0; i < N; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 32'hABCD_0000 | (i + 1);
      tick();
      if (i == N - 2) check("not_full_early", {127'b0, shadow_full}, 128'd0);
    end
    check("full_after_last", {126'b0, shadow_full, cfg_ready}, 128'd2);
    check("busy_drops", {127'b0, busy}, 128'd0);
    cfg_data = 32'h0000_00EE;
    tick();
    tick();
    cfg_valid = 1'b0;
    check("full_holds", {127'b0, shadow_full}, 128'd1);
    check("ctrl_before_commit", ctrl, rep(8'h00));
    pulse_commit();
    check("commit_ramp", ctrl, ramp(8'h01));
    check("full_drops", {126'b0, shadow_full, busy}, 128'd0);

    // Load with valid gaps; illegal commit mid-load keeps active bank
    pulse_start();
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        cfg_valid = 1'b0;
        cfg_data  = 32'h0000_0099;
        commit    = (i == 8 && g == 0);
        tick();
        commit    = 1'b0;
      end
      cfg_valid = 1'b1;
      cfg_data  = 32'h20 + i;
      tick();
    end
    cfg_valid = 1'b0;
    check("gap_err_in_load", {127'b0, err}, 128'd1);
    check("gap_ctrl_kept", ctrl, ramp(8'h01));
    check("gap_full", {127'b0, shadow_full}, 128'd1);
    pulse_commit();
    check("gap_commit", ctrl, ramp(8'h20));

    // Restart mid-load: 0xF word with restart is discarded
    pulse_start();
    check("restart_err_clr", {127'b0, err}, 128'd0);
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 32'h0A;
      tick();
    end
    load_start = 1'b1;
    cfg_data   = 32'h0F;
    tick();
    load_start = 1'b0;
    check("restart_busy", {127'b0, busy}, 128'd1);
    load_all(8'h03);
    check("restart_full", {127'b0, shadow_full}, 128'd1);
    pulse_commit();
    check("restart_commit", ctrl, rep(8'h03));

    // Commit together with restart
    pulse_start();
    load_all(8'h07);
    commit     = 1'b1;
    load_start = 1'b1;
    tick();
    commit     = 1'b0;
    load_start = 1'b0;
    check("cr_ctrl", ctrl, rep(8'h07));
    check("cr_busy_ready_full", {125'b0, busy, cfg_ready, shadow_full}, 128'd6);
    check("cr_no_err", {127'b0, err}, 128'd0);

    // Illegal commit and restart in the same cycle: error set wins
    commit     = 1'b1;
    load_start = 1'b1;
    tick();
    commit     = 1'b0;
    load_start = 1'b0;
    check("set_wins", {127'b0, err}, 128'd1);
    check("set_wins_ctrl", ctrl, rep(8'h07));

    // Active = 0x5, then async reset after 8 accepted words
    pulse_start();
    load_all(8'h05);
    pulse_commit();
    check("active5", ctrl, rep(8'h05));
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 32'h0C;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", ctrl, rep(8'h00));
    check("arst_flags", {124'b0, cfg_ready, busy, shadow_full, err}, 128'd0);
    cfg_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    pulse_commit();
    check("post_rst_commit_err", {127'b0, err}, 128'd1);
    check("post_rst_commit_ctrl", ctrl, rep(8'h00));
    pulse_start();
    load_all(8'h06);
    pulse_commit();
    check("reload_commit", ctrl, rep(8'h06));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
